// File: rtl/lemmings_world.sv
// rtl/lemmings_world.sv - terrain model driving a lemming: walls, one hole, optional dig site
// Optional dig support is compiled in when LEMMINGS_WORLD_DIG_EN is defined.
module lemmings_world #(
   parameter int PW         = 5,
   parameter int START_POS  = 16,
   parameter int RIGHT_WALL = 31,
   parameter int HOLE_POS   = 20,
   parameter int HOLE_DEPTH = 4,
   parameter int DIG_POS    = 10,
   parameter int DIG_CYCLES = 3
) (
   input  logic clk,
   input  logic rstn,
   input  logic walk_left,
   input  logic walk_right,
   input  logic aaah,
   input  logic digging,
   output logic bump_left,
   output logic bump_right,
   output logic ground,
   output logic dig
);

   localparam int FW = (HOLE_DEPTH > 1) ? $clog2(HOLE_DEPTH) : 1;
   localparam int DW = (DIG_CYCLES > 0) ? $clog2(DIG_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_DIG    = 2'd1,
      ST_FALL   = 2'd2
   } state_t;

   state_t        state;
   logic [PW-1:0] pos;
   logic [FW-1:0] fall_cnt;
   logic [DW-1:0] dig_cnt;
   logic          hole_used;
   logic          dig_done;

   logic          walk_r;
   logic          walk_l;
   logic          hit_right;
   logic          hit_left;
   logic [PW-1:0] pos_upd;
   logic          moved;
   logic          hole_hit;
   logic          dig_offer;
   logic [DW-1:0] dig_cnt_nxt;

   // aaah is only watched by the lemming; digging goes unread when dig support is off
   logic unused_inputs;
   assign unused_inputs = &{1'b0, aaah, digging, dig_cnt, dig_done, dig_offer, dig_cnt_nxt};

   // Position the lemming would take this cycle if it were on the ground
   always_comb begin
      walk_r    = walk_right & ~walk_left;
      walk_l    = walk_left & ~walk_right;
      hit_right = walk_r && (pos == PW'(RIGHT_WALL));
      hit_left  = walk_l && (pos == '0);
      pos_upd   = pos;
      if (walk_r && !hit_right) begin
         pos_upd = pos + 1'b1;
      end else if (walk_l && !hit_left) begin
         pos_upd = pos - 1'b1;
      end
      moved       = (pos_upd != pos);
      hole_hit    = (pos_upd == PW'(HOLE_POS)) && !hole_used;
      // The dig site is offered only on arrival, so standing still never repeats the pulse
      dig_offer   = moved && (pos_upd == PW'(DIG_POS)) && !dig_done;
      dig_cnt_nxt = dig_cnt + 1'b1;
   end

   // Terrain state machine; every output is a register updated here
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= ST_GROUND;
         pos        <= PW'(START_POS);
         fall_cnt   <= '0;
         dig_cnt    <= '0;
         hole_used  <= 1'b0;
         dig_done   <= 1'b0;
         bump_left  <= 1'b0;
         bump_right <= 1'b0;
         ground     <= 1'b1;
         dig        <= 1'b0;
      end else begin
         bump_left  <= 1'b0;
         bump_right <= 1'b0;
         dig        <= 1'b0;
         case (state)
            ST_GROUND: begin
`ifdef LEMMINGS_WORLD_DIG_EN
               if (digging && ground) begin
                  // First digging cycle counts as one; the lemming stays put while digging
                  if (DIG_CYCLES <= 1) begin
                     ground   <= 1'b0;
                     dig_done <= 1'b1;
                     fall_cnt <= '0;
                     dig_cnt  <= '0;
                     state    <= ST_FALL;
                  end else begin
                     dig_cnt  <= DW'(1);
                     state    <= ST_DIG;
                  end
               end else
`endif
               begin
                  pos        <= pos_upd;
                  bump_left  <= hit_left;
                  bump_right <= hit_right;
                  if (hole_hit) begin
                     // Hole wins over a dig offer on the same column/cycle
                     ground    <= 1'b0;
                     fall_cnt  <= '0;
                     hole_used <= 1'b1;
                     state     <= ST_FALL;
                  end
`ifdef LEMMINGS_WORLD_DIG_EN
                  else if (dig_offer) begin
                     dig <= 1'b1;
                  end
`endif
               end
            end
`ifdef LEMMINGS_WORLD_DIG_EN
            ST_DIG: begin
               if (digging) begin
                  dig_cnt <= dig_cnt_nxt;
                  if (dig_cnt_nxt == DW'(DIG_CYCLES)) begin
                     ground   <= 1'b0;
                     dig_done <= 1'b1;
                     fall_cnt <= '0;
                     dig_cnt  <= '0;
                     state    <= ST_FALL;
                  end
               end else begin
                  // Gave up digging: back on solid ground, progress lost
                  dig_cnt <= '0;
                  state   <= ST_GROUND;
               end
            end
`endif
            ST_FALL: begin
               // Ground stays low HOLE_DEPTH cycles counting the entry cycle
               if (fall_cnt == FW'(HOLE_DEPTH - 1)) begin
                  ground   <= 1'b1;
                  fall_cnt <= '0;
                  state    <= ST_GROUND;
               end else begin
                  fall_cnt <= fall_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_GROUND;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lemmings_world.sv
// tb/tb_lemmings_world.sv - scoreboard bench for lemmings_world (walls, hole, dig site, reset)
module tb_lemmings_world;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic walk_left = 1'b0;
   logic walk_right = 1'b0;
   logic aaah = 1'b0;
   logic digging = 1'b0;
   logic bump_left;
   logic bump_right;
   logic ground;
   logic dig;

   typedef struct {
      logic [3:0] exp;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail = 0;

`ifdef LEMMINGS_WORLD_DIG_EN
   localparam logic DIG_ON = 1'b1;
`else
   localparam logic DIG_ON = 1'b0;
`endif

   // Expected {bump_left, bump_right, ground, dig}
   localparam logic [3:0] IDLE = 4'b0010;
   localparam logic [3:0] LOW  = 4'b0000;
   localparam logic [3:0] BL   = 4'b1010;
   localparam logic [3:0] BR   = 4'b0110;
   localparam logic [3:0] DIGP = {3'b001, DIG_ON};
   localparam logic [3:0] GD   = DIG_ON ? 4'b0000 : 4'b0010;

   always #5 clk = ~clk;

   lemmings_world dut (
      .clk        (clk),
      .rstn       (rstn),
      .walk_left  (walk_left),
      .walk_right (walk_right),
      .aaah       (aaah),
      .digging    (digging),
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .ground     (ground),
      .dig        (dig)
   );

   // Monitor: one expectation per clock edge, sampled just after the edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_tests++;
         if ({bump_left, bump_right, ground, dig} !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got bl=%b br=%b gnd=%b dig=%b, required bl=%b br=%b gnd=%b dig=%b",
                     e.name, bump_left, bump_right, ground, dig,
                     e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
         end
      end
   end

   task automatic step(input logic r, input logic wl, input logic wr, input logic dg,
                       input logic [3:0] exp, input string name);
      exp_t e;
      @(negedge clk);
      rstn       = r;
      walk_left  = wl;
      walk_right = wr;
      digging    = dg;
      aaah       = 1'($urandom_range(0, 1));
      e.exp      = exp;
      e.name     = name;
      sb_q.push_back(e);
   endtask

   initial begin
      // Hole: walk right from 16, fall 4 cycles at 20, then walls
      step(0, 0, 0, 0, IDLE, "reset");
      step(0, 1, 0, 0, IDLE, "reset_with_walk");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, IDLE, "walk_r_to_19");
      step(1, 0, 1, 0, LOW, "hole_enter");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, LOW, "falling");
      step(1, 0, 1, 0, IDLE, "landed");
      for (int i = 0; i < 11; i++) step(1, 0, 1, 0, IDLE, "walk_r_to_31");
      step(1, 0, 1, 0, BR, "bump_right");
      step(1, 1, 1, 0, IDLE, "both_high");
      step(1, 1, 1, 0, IDLE, "both_high_2");
      for (int i = 0; i < 15; i++) step(1, 1, 0, 0, IDLE, "repass_used_hole");

      // Left wall: 16 steps to 0, then repeated bumps
      step(0, 1, 0, 0, IDLE, "reset_b");
      for (int i = 1; i <= 16; i++) step(1, 1, 0, 0, (i == 6) ? DIGP : IDLE, "walk_l_to_0");
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, BL, "bump_left");
      step(1, 0, 0, 0, IDLE, "bump_clear");
      step(1, 1, 1, 0, IDLE, "both_high_at_0");

      // Reset in the second cycle of a fall, then the hole works again
      step(0, 0, 0, 0, IDLE, "reset_c");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, IDLE, "walk_r_c");
      step(1, 0, 1, 0, LOW, "hole_enter_c");
      step(1, 0, 1, 0, LOW, "fall_2_c");
      step(0, 0, 1, 0, IDLE, "reset_mid_fall");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, IDLE, "walk_r_again");
      step(1, 0, 1, 0, LOW, "hole_retrigger");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, LOW, "falling_again");
      step(1, 0, 0, 0, IDLE, "landed_again");

      // Dig through at column 10
      step(0, 0, 0, 0, IDLE, "reset_d");
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, IDLE, "walk_l_d");
      step(1, 1, 0, 0, DIGP, "dig_offer");
      step(1, 0, 0, 1, IDLE, "dig_1");
      step(1, 0, 0, 1, IDLE, "dig_2");
      step(1, 0, 0, 1, GD, "dig_through");
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, GD, "dig_fall");
      step(1, 0, 0, 0, IDLE, "dig_land");
      step(1, 0, 1, 0, IDLE, "leave_dig_site");
      step(1, 1, 0, 0, IDLE, "no_reoffer_after_dig");

      // Abandoned dig keeps the lemming in place; the site is offered again on return
      step(0, 0, 0, 0, IDLE, "reset_e");
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, IDLE, "walk_l_e");
      step(1, 1, 0, 0, DIGP, "dig_offer_e");
      step(1, 0, 0, 1, IDLE, "dig_partial_1");
      step(1, 0, 0, 1, IDLE, "dig_partial_2");
      step(1, 1, 0, 0, IDLE, "dig_abort");
      step(1, 1, 0, 0, IDLE, "walk_to_9");
      step(1, 0, 1, 0, DIGP, "reoffer_at_10");
      step(1, 0, 0, 1, IDLE, "redig_1");
      step(1, 0, 0, 1, IDLE, "redig_2");
      step(1, 0, 0, 1, GD, "redig_through");
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, GD, "redig_fall");
      step(1, 0, 0, 0, IDLE, "redig_land");

      begin
         int w;
         w = 0;
         while (sb_q.size() > 0 && w < 20) begin
            @(posedge clk);
            w++;
         end
         repeat (2) @(posedge clk);
         #2;
         if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
